// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES ripple segments with a
// registered carry between them, behind a valid/ready handshake that stalls globally.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic              advance_s;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              msb_cin_s;
  logic              ovf_d;
  logic              ovf_q;
  logic              zero_d;
  logic              zero_q;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be a positive multiple of STAGES");
  end

  assign advance_s = !vld_q[LAST] || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_q;
    logic [SEG-1:0]   a_seg_s;
    logic [SEG-1:0]   b_seg_s;
    logic [SEG-1:0]   sum_s;
    logic             c_in_s;
    logic             c_out_s;
    logic             cry_q;

    if (k == 0) begin : g_src
      assign base_s  = a;
      assign b_seg_s = b[SEG-1:0] ^ {SEG{sub}};
      assign c_in_s  = sub | cin;
    end else begin : g_src
      assign base_s  = g_stage[k-1].acc_q;
      assign b_seg_s = g_stage[k-1].g_skew.bx_q[SEG-1:0];
      assign c_in_s  = g_stage[k-1].cry_q;
    end

    assign a_seg_s = base_s[k*SEG +: SEG];
    assign {c_out_s, sum_s} = {1'b0, a_seg_s} + {1'b0, b_seg_s} + {{SEG{1'b0}}, c_in_s};

    // Lower segments already hold sums, upper segments still hold raw A; splice in this one.
    always_comb begin
      acc_d = base_s;
      acc_d[k*SEG +: SEG] = sum_s;
    end

    // Partial-sum word and segment carry register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q <= {WIDTH{1'b0}};
        cry_q <= 1'b0;
      end else if (advance_s) begin
        acc_q <= acc_d;
        cry_q <= c_out_s;
      end else begin
        acc_q <= acc_q;
        cry_q <= cry_q;
      end
    end

    if (k < LAST) begin : g_skew
      localparam int REM = WIDTH - (k + 1) * SEG;
      logic [REM-1:0] bx_d;
      logic [REM-1:0] bx_q;

      if (k == 0) begin : g_first
        assign bx_d = b[WIDTH-1:SEG] ^ {REM{sub}};
      end else begin : g_next
        assign bx_d = g_stage[k-1].g_skew.bx_q[REM+SEG-1:SEG];
      end

      // Skew register carrying the not-yet-consumed segments of the inverted-or-not B.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bx_q <= {REM{1'b0}};
        end else if (advance_s) begin
          bx_q <= bx_d;
        end else begin
          bx_q <= bx_q;
        end
      end
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its two addend bits.
  assign msb_cin_s = g_stage[LAST].a_seg_s[SEG-1] ^ g_stage[LAST].b_seg_s[SEG-1]
                   ^ g_stage[LAST].sum_s[SEG-1];
  assign ovf_d     = msb_cin_s ^ g_stage[LAST].c_out_s;
  assign zero_d    = (g_stage[LAST].acc_d == {WIDTH{1'b0}});

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  // Valid shift register and last-stage flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= {STAGES{1'b0}};
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance_s) begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end else begin
      vld_q  <= vld_q;
      ovf_q  <= ovf_q;
      zero_q <= zero_q;
    end
  end

  assign out_valid = vld_q[LAST];
  assign result    = g_stage[LAST].acc_q;
  assign carry_out = g_stage[LAST].cry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: table vectors, backpressure and reset sequences on a 32/4
// instance, plus random scoreboard traffic on 8/1 and 64/8 instances.
module tb_pipelined_add_sub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  logic        iv32, ir32, sub32, cin32, vo32, ordy32, co32, ovf32, z32;
  logic [31:0] a32, b32, res32;
  logic        iv8, ir8, sub8, cin8, vo8, ordy8, co8, ovf8, z8;
  logic [7:0]  a8, b8, res8;
  logic        iv64, ir64, sub64, cin64, vo64, ordy64, co64, ovf64, z64;
  logic [63:0] a64, b64, res64;

  int checks = 0;
  int errors = 0;
  int ret32 = 0;
  int ret8 = 0;
  int ret64 = 0;
  logic [67:0] q32[$];
  logic [67:0] q8[$];
  logic [67:0] q64[$];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub32), .cin(cin32), .out_valid(vo32), .out_ready(ordy32), .result(res32),
    .carry_out(co32), .overflow(ovf32), .zero(z32));

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .cin(cin8), .out_valid(vo8), .out_ready(ordy8), .result(res8),
    .carry_out(co8), .overflow(ovf8), .zero(z8));

  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .sub(sub64), .cin(cin64), .out_valid(vo64), .out_ready(ordy64), .result(res64),
    .carry_out(co64), .overflow(ovf64), .zero(z64));

  task automatic check(input string nm, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: {pad, zero, overflow, carry_out, result} for a w-bit add/subtract.
  function automatic logic [67:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                        input logic s, input logic c);
    logic [63:0] mask, am, bm, r;
    logic [64:0] t;
    logic        co, ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    bm   = (s ? ~bv : bv) & mask;
    t    = {1'b0, am} + {1'b0, bm} + {64'd0, (s ? 1'b1 : c)};
    co   = t[w];
    r    = t[63:0] & mask;
    ov   = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    return {1'b0, (r == 64'd0), ov, co, r};
  endfunction

  // Scoreboards: push on accept, pop and compare on retire, both judged at the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q32.delete();
    end else begin
      if (vo32 && ordy32) begin
        ret32++;
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb32_extra: got result %h expected no result", res32);
        end else begin
          check("sb32", {1'b0, z32, ovf32, co32, 32'd0, res32}, q32.pop_front());
        end
      end
      if (iv32 && ir32) q32.push_back(model(32, {32'd0, a32}, {32'd0, b32}, sub32, cin32));
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q8.delete();
    end else begin
      if (vo8 && ordy8) begin
        ret8++;
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb8_extra: got result %h expected no result", res8);
        end else begin
          check("sb8", {1'b0, z8, ovf8, co8, 56'd0, res8}, q8.pop_front());
        end
      end
      if (iv8 && ir8) q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, sub8, cin8));
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q64.delete();
    end else begin
      if (vo64 && ordy64) begin
        ret64++;
        if (q64.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb64_extra: got result %h expected no result", res64);
        end else begin
          check("sb64", {1'b0, z64, ovf64, co64, res64}, q64.pop_front());
        end
      end
      if (iv64 && ir64) q64.push_back(model(64, a64, b64, sub64, cin64));
    end
  end

  // One beat into an empty 32/4 pipe: invisible after 3 edges, visible after the 4th.
  task automatic apply_vec(input vec_t v, input int id);
    a32 = v.a; b32 = v.b; sub32 = v.sub; cin32 = v.cin; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("vec%0d_early", id), 68'(vo32), 68'd0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_valid", id), 68'(vo32), 68'd1);
    check($sformatf("vec%0d_out", id), {1'b0, z32, ovf32, co32, 32'd0, res32},
          {1'b0, v.z, v.ov, v.co, 32'd0, v.res});
  endtask

  initial begin
    vec_t        tbl [7];
    vec_t        v;
    int          idx, r0, n8, n64;
    logic        acc, acc8, acc64, stall_prev;
    logic [31:0] held;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    iv32 = 1'b0; a32 = 32'd0; b32 = 32'd0; sub32 = 1'b0; cin32 = 1'b0; ordy32 = 1'b1;
    iv8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;  sub8  = 1'b0; cin8  = 1'b0; ordy8  = 1'b1;
    iv64 = 1'b0; a64 = 64'd0; b64 = 64'd0; sub64 = 1'b0; cin64 = 1'b0; ordy64 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 68'(ir32), 68'd1);
    check("rst_out_valid", 68'(vo32), 68'd0);
    check("rst_result", 68'(res32), 68'd0);
    check("rst_flags", 68'({co32, ovf32, z32}), 68'd0);
    check("rst_out_valid_w8", 68'(vo8), 68'd0);
    check("rst_out_valid_w64", 68'(vo64), 68'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(tbl[i], i);
    repeat (3) @(posedge clk);
    #1;

    // Ten back-to-back beats a=b=i with the sink stalled for cycles 6..9.
    r0 = ret32; idx = 0; stall_prev = 1'b0; held = 32'd0;
    for (int c = 0; c < 30; c++) begin
      ordy32 = !((c >= 6) && (c <= 9));
      iv32 = (idx < 10); a32 = 32'(idx); b32 = 32'(idx); sub32 = 1'b0; cin32 = 1'b0;
      @(negedge clk);
      if (!ordy32) begin
        check("bp_in_ready", 68'(ir32), 68'd0);
        check("bp_out_valid", 68'(vo32), 68'd1);
        if (stall_prev) check("bp_hold", 68'(res32), 68'(held));
        held = res32;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      acc = iv32 && ir32;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_accepted", 68'(idx), 68'd10);
    check("bp_delivered", 68'(ret32 - r0), 68'd10);
    check("bp_sb_empty", 68'(q32.size()), 68'd0);

    // Reset while beats are in flight: nothing from them may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      a32 = 32'(i + 1); b32 = 32'(i + 1); iv32 = 1'b1;
      if (i < 2) begin
        @(posedge clk); #1;
      end else begin
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 68'(vo32), 68'd0);
        check("rst_mid_in_ready", 68'(ir32), 68'd1);
      end
    end
    iv32 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_out_valid", 68'(vo32), 68'd0);
      check("rst_hold_in_ready", 68'(ir32), 68'd1);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 68'(vo32), 68'd0);
    end
    @(posedge clk); #1;
    v = '{32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0};
    apply_vec(v, 7);

    // Random traffic with random backpressure on the 8/1 and 64/8 instances.
    n8 = 0; n64 = 0;
    for (int cyc = 0; (cyc < 20000) && ((n8 < 1000) || (n64 < 1000)); cyc++) begin
      iv8    = (n8 < 1000) && ($urandom_range(0, 3) != 0);
      a8     = 8'($urandom); b8 = 8'($urandom);
      sub8   = 1'($urandom_range(0, 1)); cin8 = 1'($urandom_range(0, 1));
      ordy8  = ($urandom_range(0, 3) != 0);
      iv64   = (n64 < 1000) && ($urandom_range(0, 3) != 0);
      a64    = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      sub64  = 1'($urandom_range(0, 1)); cin64 = 1'($urandom_range(0, 1));
      ordy64 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc8  = iv8 && ir8;
      acc64 = iv64 && ir64;
      @(posedge clk); #1;
      if (acc8) n8++;
      if (acc64) n64++;
    end
    iv8 = 1'b0; iv64 = 1'b0; ordy8 = 1'b1; ordy64 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("w8_accepted", 68'(n8), 68'd1000);
    check("w8_delivered", 68'(ret8), 68'd1000);
    check("w8_sb_empty", 68'(q8.size()), 68'd0);
    check("w64_accepted", 68'(n64), 68'd1000);
    check("w64_delivered", 68'(ret64), 68'd1000);
    check("w64_sb_empty", 68'(q64.size()), 68'd0);
    check("w32_sb_empty", 68'(q32.size()), 68'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
